// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: window, tag, coefficient bank and
// MAC arithmetic widths.
package conv_pkg;
  localparam int PIXEL_W           = 8;
  localparam int KERNEL_DIAMETER_N = 5;
  localparam int KERNEL_TAPS_N     = KERNEL_DIAMETER_N ** 2;
  localparam int COEF_W            = 8;
  localparam int POS_W             = 12;
  localparam int PROD_W            = PIXEL_W + COEF_W + 1;
  localparam int ACC_W             = PROD_W + 5;

  typedef logic [KERNEL_DIAMETER_N-1:0][KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0] kernel_t;
  typedef logic [KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0] kernel_row_t;

  typedef struct packed {
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] x;
  } kernel_pos_t;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [4:0] coef_addr_t;
  typedef logic [KERNEL_TAPS_N-1:0][COEF_W-1:0] coef_bank_t;
  typedef logic [KERNEL_DIAMETER_N-1:0][COEF_W-1:0] coef_row_t;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/conv_mac_row.sv
// One kernel row: five pixel*coefficient products (S1) reduced to a row sum (S2).
module conv_mac_row
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        vld_p0,
  input  logic        vld_p1,
  input  kernel_row_t pix_p0,
  input  coef_row_t   coef,
  output acc_t        sum_p2
);

  prod_t prod_p1 [KERNEL_DIAMETER_N];
  acc_t  row_sum;

  // S1: pixels are unsigned, so zero-extend before the signed multiply
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      for (int c = 0; c < KERNEL_DIAMETER_N; c++) begin
        prod_p1[c] <= prod_t'(signed'({1'b0, pix_p0[c]})) * prod_t'(coef_t'(coef[c]));
      end
    end
  end

  always_comb begin
    row_sum = '0;
    for (int c = 0; c < KERNEL_DIAMETER_N; c++) begin
      row_sum = row_sum + acc_t'(prod_p1[c]);
    end
  end

  // S2
  always_ff @(posedge clk) begin
    if (vld_p1) sum_p2 <= row_sum;
  end

endmodule

// File: rtl/conv_mac.sv
// KxK signed-coefficient MAC with double-buffered coefficient bank, 4-cycle latency.
// Optional clamp-event counter enabled by defining CONV_MAC_SAT_STATS_EN.
module conv_mac
  import conv_pkg::*;
#(
  parameter int NORM_SHIFT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kernel_vld_i,
  input  kernel_t             kernel_dat_i,
  input  kernel_pos_t         kernel_pos_i,
  input  logic                coef_wr_i,
  input  coef_addr_t          coef_addr_i,
  input  coef_t               coef_dat_i,
  input  logic                coef_commit_i,
  output logic                out_vld_o,
  output logic [PIXEL_W-1:0]  out_dat_o,
  output kernel_pos_t         out_pos_o,
  output logic [15:0]         sat_cnt_o
);

  localparam int    CENTRE_TAP = KERNEL_TAPS_N / 2;
  localparam int    PIX_MAX    = 2 ** PIXEL_W - 1;
  localparam coef_t COEF_MAX   = coef_t'(2 ** (COEF_W - 1) - 1);
  localparam coef_t ID_CENTRE  = (NORM_SHIFT >= COEF_W - 1) ? COEF_MAX : coef_t'(1 << NORM_SHIFT);

  function automatic coef_bank_t identity_bank();
    coef_bank_t b;
    b = '0;
    b[CENTRE_TAP] = ID_CENTRE;
    return b;
  endfunction

  function automatic acc_t round_shift(acc_t s);
    acc_t half;
    half = acc_t'(1) <<< (NORM_SHIFT - 1);
    return (s + half) >>> NORM_SHIFT;
  endfunction

  function automatic logic is_clamped(acc_t r);
    return (r < 0) || (r > acc_t'(PIX_MAX));
  endfunction

  function automatic logic [PIXEL_W-1:0] clamp_pix(acc_t r);
    if (r < 0) return '0;
    if (r > acc_t'(PIX_MAX)) return '1;
    return r[PIXEL_W-1:0];
  endfunction

  coef_bank_t  shadow, shadow_nxt, active;
  logic        vld_p1, vld_p2, vld_p3;
  kernel_pos_t pos_p1, pos_p2, pos_p3;
  acc_t        row_sum_p2 [KERNEL_DIAMETER_N];
  acc_t        sum_p3, total_p2, rnd_p3;

  // The committed bank includes a write landing in the same cycle
  always_comb begin
    shadow_nxt = shadow;
    if (coef_wr_i && (coef_addr_i < coef_addr_t'(KERNEL_TAPS_N))) begin
      shadow_nxt[coef_addr_i] = coef_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= identity_bank();
      active <= identity_bank();
    end else begin
      shadow <= shadow_nxt;
      if (coef_commit_i) active <= shadow_nxt;
    end
  end

  for (genvar r = 0; r < KERNEL_DIAMETER_N; r++) begin : g_row
    conv_mac_row u_row (
      .clk    (clk),
      .vld_p0 (kernel_vld_i),
      .vld_p1 (vld_p1),
      .pix_p0 (kernel_dat_i[r]),
      .coef   (active[r*KERNEL_DIAMETER_N +: KERNEL_DIAMETER_N]),
      .sum_p2 (row_sum_p2[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_vld_o <= 1'b0;
    end else begin
      vld_p1    <= kernel_vld_i;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_vld_o <= vld_p3;
    end
  end

  // S1/S2 tag stages track the row sub-modules
  always_ff @(posedge clk) begin
    if (kernel_vld_i) pos_p1 <= kernel_pos_i;
    if (vld_p1)       pos_p2 <= pos_p1;
  end

  always_comb begin
    total_p2 = '0;
    for (int r = 0; r < KERNEL_DIAMETER_N; r++) begin
      total_p2 = total_p2 + row_sum_p2[r];
    end
  end

  // S3
  always_ff @(posedge clk) begin
    if (vld_p2) begin
      sum_p3 <= total_p2;
      pos_p3 <= pos_p2;
    end
  end

  assign rnd_p3 = round_shift(sum_p3);

  // S4
  always_ff @(posedge clk) begin
    if (rst) begin
      out_dat_o <= '0;
      out_pos_o <= '0;
    end else if (vld_p3) begin
      out_dat_o <= clamp_pix(rnd_p3);
      out_pos_o <= pos_p3;
    end
  end

`ifdef CONV_MAC_SAT_STATS_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (vld_p3 && is_clamped(rnd_p3) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`else
  assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac: scoreboard of expected pixels/tags/arrival cycles
// computed from a bench-side coefficient model.
module tb_conv_mac;
  import conv_pkg::*;

  localparam int NS = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         kernel_vld_i;
  kernel_t      kernel_dat_i;
  kernel_pos_t  kernel_pos_i;
  logic         coef_wr_i;
  coef_addr_t   coef_addr_i;
  coef_t        coef_dat_i;
  logic         coef_commit_i;
  logic         out_vld_o;
  logic [7:0]   out_dat_o;
  kernel_pos_t  out_pos_o;
  logic [15:0]  sat_cnt_o;

  conv_mac #(.NORM_SHIFT(NS)) dut (
    .clk           (clk),
    .rst           (rst),
    .kernel_vld_i  (kernel_vld_i),
    .kernel_dat_i  (kernel_dat_i),
    .kernel_pos_i  (kernel_pos_i),
    .coef_wr_i     (coef_wr_i),
    .coef_addr_i   (coef_addr_i),
    .coef_dat_i    (coef_dat_i),
    .coef_commit_i (coef_commit_i),
    .out_vld_o     (out_vld_o),
    .out_dat_o     (out_dat_o),
    .out_pos_o     (out_pos_o),
    .sat_cnt_o     (sat_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dat;
    kernel_pos_t pos;
    int          due;
    int          clamp;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t e;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int exp_sat = 0;
  int shadow_m [KERNEL_TAPS_N];
  int active_m [KERNEL_TAPS_N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void reset_model();
    for (int i = 0; i < KERNEL_TAPS_N; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end
    shadow_m[12] = 127;
    active_m[12] = 127;
  endfunction

  function automatic kernel_t fill(input logic [7:0] others, input logic [7:0] centre);
    kernel_t k;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) k[r][c] = others;
    k[2][2] = centre;
    return k;
  endfunction

  function automatic kernel_t rnd_k();
    kernel_t k;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) k[r][c] = 8'($urandom);
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the expectation uses the bank active before this edge
  task automatic step(input logic vld, input kernel_t k, input int tag, input logic wr,
                      input int addr, input int dat, input logic commit);
    sb_item_t it;
    int sum;
    int r;
    kernel_vld_i  = vld;
    kernel_dat_i  = k;
    kernel_pos_i  = kernel_pos_t'(24'(tag));
    coef_wr_i     = wr;
    coef_addr_i   = coef_addr_t'(addr);
    coef_dat_i    = coef_t'(dat);
    coef_commit_i = commit;
    if (vld) begin
      sum = 0;
      for (int rr = 0; rr < 5; rr++)
        for (int c = 0; c < 5; c++) sum += int'(k[rr][c]) * active_m[rr*5 + c];
      r = (sum + (1 << (NS - 1))) >>> NS;
      it.clamp = (r < 0 || r > 255) ? 1 : 0;
      it.dat   = (r < 0) ? 8'h00 : (r > 255) ? 8'hFF : 8'(r);
      it.pos   = kernel_pos_t'(24'(tag));
      it.due   = cyc + 4;
      sb.push_back(it);
    end
    if (wr && addr < KERNEL_TAPS_N) shadow_m[addr] = dat;
    if (commit) active_m = shadow_m;
    tick();
    kernel_vld_i  = 1'b0;
    coef_wr_i     = 1'b0;
    coef_commit_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr_coef(input int addr, input int dat);
    step(1'b0, '0, 0, 1'b1, addr, dat, 1'b0);
  endtask

  task automatic commit();
    step(1'b0, '0, 0, 1'b0, 0, 0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (out_vld_o === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_vld observed=1 expected=0 cyc=%0d", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
`ifdef CONV_MAC_SAT_STATS_EN
        exp_sat += e.clamp;
`endif
        n_cmp++;
        assert (out_dat_o === e.dat) else begin
          n_err++;
          $error("FAIL out_dat observed=%0h expected=%0h", out_dat_o, e.dat);
        end
        n_cmp++;
        assert (out_pos_o === e.pos) else begin
          n_err++;
          $error("FAIL out_pos observed=%0h expected=%0h", out_pos_o, e.pos);
        end
        n_cmp++;
        assert (cyc === e.due) else begin
          n_err++;
          $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, e.due);
        end
        n_cmp++;
        assert (int'(sat_cnt_o) === exp_sat) else begin
          n_err++;
          $error("FAIL sat_cnt observed=%0d expected=%0d", sat_cnt_o, exp_sat);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    kernel_vld_i = 1'b0; kernel_dat_i = '0; kernel_pos_i = '0;
    coef_wr_i = 1'b0; coef_addr_i = '0; coef_dat_i = '0; coef_commit_i = 1'b0;
    reset_model();
    tick(); tick();
    chk("rst_vld", 32'(out_vld_o), 0);
    chk("rst_dat", 32'(out_dat_o), 0);
    chk("rst_pos", 32'(out_pos_o), 0);
    chk("rst_sat", 32'(sat_cnt_o), 0);
    rst = 1'b0;
    tick();

    // identity bank straight out of reset
    step(1'b1, fill(8'hFF, 8'h5A), 24'h00A05, 1'b0, 0, 0, 1'b0);
    idle(6);

    // uniform coefficient 10
    for (int i = 0; i < 25; i++) wr_coef(i, 10);
    commit();
    step(1'b1, fill(8'h40, 8'h40), 101, 1'b0, 0, 0, 1'b0);
    idle(6);

    // centre 127 only: largest value that avoids the clamp
    for (int i = 0; i < 25; i++) wr_coef(i, (i == 12) ? 127 : 0);
    commit();
    step(1'b1, fill(8'hFF, 8'hFF), 102, 1'b0, 0, 0, 1'b0);
    idle(6);

    // all 127: positive clamp
    for (int i = 0; i < 25; i++) wr_coef(i, 127);
    commit();
    step(1'b1, fill(8'hFF, 8'hFF), 103, 1'b0, 0, 0, 1'b0);
    idle(6);

    // centre -128: negative clamp
    for (int i = 0; i < 25; i++) wr_coef(i, (i == 12) ? -128 : 0);
    commit();
    step(1'b1, fill(8'h80, 8'h80), 104, 1'b0, 0, 0, 1'b0);
    idle(6);

    // back-to-back stream, write+commit mid-stream, later write not committed
    for (int i = 0; i < 25; i++) wr_coef(i, (i == 12) ? 100 : (i % 7) - 3);
    for (int w = 0; w < 10; w++) begin
      if (w == 3)      step(1'b1, rnd_k(), 200 + w, 1'b1, 6, 50, 1'b1);
      else if (w == 5) step(1'b1, rnd_k(), 200 + w, 1'b1, 7, 20, 1'b0);
      else             step(1'b1, rnd_k(), 200 + w, 1'b0, 0, 0, 1'b0);
    end
    idle(6);

    // out-of-range writes must not alias onto real taps
    wr_coef(25, 99);
    wr_coef(28, 99);
    wr_coef(31, -77);
    commit();
    step(1'b1, rnd_k(), 300, 1'b0, 0, 0, 1'b0);
    step(1'b1, fill(8'h11, 8'h22), 301, 1'b0, 0, 0, 1'b0);
    idle(6);

    // reset with three windows in flight
    step(1'b1, rnd_k(), 400, 1'b0, 0, 0, 1'b0);
    step(1'b1, rnd_k(), 401, 1'b0, 0, 0, 1'b0);
    step(1'b1, rnd_k(), 402, 1'b0, 0, 0, 1'b0);
    sb.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_model();
    exp_sat = 0;
    chk("inflight_rst_vld", 32'(out_vld_o), 0);
    chk("inflight_rst_sat", 32'(sat_cnt_o), 0);
    idle(6);
    step(1'b1, fill(8'h33, 8'hC8), 500, 1'b0, 0, 0, 1'b0);
    commit();
    step(1'b1, rnd_k(), 501, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    chk("drain", 32'(sb.size()), 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
